// File: rtl/bus_arbiter_pkg.sv
// Shared types, constants and helpers for the four-master round-robin bus arbiter.
package bus_arbiter_pkg;

    localparam int BUS_MASTER_CH = 4;
    localparam int BUS_OWNER_W   = 2;
    localparam int BUS_ARB_TMO_W = 16;

    // Levels for the active-low request/grant handshake.
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef logic [BUS_OWNER_W-1:0]   bus_owner_t;
    typedef logic [BUS_MASTER_CH-1:0] bus_req_t;
    typedef logic [BUS_ARB_TMO_W-1:0] bus_arb_tmo_t;

    typedef enum logic {
        BUS_ARB_STATE_IDLE  = 1'b0,
        BUS_ARB_STATE_GRANT = 1'b1
    } bus_arb_state_t;

    function automatic bus_req_t grant_vec(input bus_owner_t idx);
        bus_req_t v;
        v      = {BUS_MASTER_CH{DISABLE_}};
        v[idx] = ENABLE_;
        return v;
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// Combinational round-robin pick: first active-low request after the last owner,
// wrapping, so the last owner is considered last.
module bus_arb_rr_pick
    import bus_arbiter_pkg::*;
(
    input  logic [BUS_MASTER_CH-1:0] req_n_i,
    input  logic [BUS_OWNER_W-1:0]   last_i,
    output logic [BUS_OWNER_W-1:0]   win_o,
    output logic                     vld_o
);

    bus_owner_t idx;

    // Walk from lowest to highest priority so the nearest requester overwrites.
    always_comb begin
        win_o = last_i;
        vld_o = 1'b0;
        idx   = last_i;
        for (int k = BUS_MASTER_CH; k >= 1; k--) begin
            idx = last_i + bus_owner_t'(k);
            if (req_n_i[idx] == ENABLE_) begin
                win_o = idx;
                vld_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for four bus masters with active-low request/grant.
// Optional grant timeout is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     clk,
    input  logic                     reset_,
    input  logic [BUS_MASTER_CH-1:0] BusReq_,
    output logic [BUS_MASTER_CH-1:0] BusGrnt_,
    output logic [BUS_OWNER_W-1:0]   BusOwner,
    output logic                     ArbBusy,
    output logic                     ArbTimeout
);

    bus_arb_state_t state_q;
    bus_owner_t     owner_q;
    bus_req_t       grnt_q;
    logic           busy_q;

    bus_req_t       req_pick;
    bus_owner_t     win_d;
    logic           win_vld_d;
    logic           owner_req;
    logic           tmo_hit;

    assign owner_req = (BusReq_[owner_q] == ENABLE_);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam bus_arb_tmo_t TMO_LAST = bus_arb_tmo_t'(TIMEOUT_CYCLES - 1);

    logic         tmo_q;
    bus_arb_tmo_t cnt_q;

    assign tmo_hit = (state_q == BUS_ARB_STATE_GRANT) && owner_req && (cnt_q == TMO_LAST);
    // A revoked owner is masked out so the pick only considers the others.
    assign req_pick   = BusReq_ | (tmo_hit ? ~grnt_q : '0);
    assign ArbTimeout = tmo_q;
`else
    logic unused_tmo;

    assign unused_tmo = |TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
    assign req_pick   = BusReq_;
    assign ArbTimeout = 1'b0;
`endif

    bus_arb_rr_pick u_pick (
        .req_n_i (req_pick),
        .last_i  (owner_q),
        .win_o   (win_d),
        .vld_o   (win_vld_d)
    );

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q <= BUS_ARB_STATE_IDLE;
            owner_q <= '0;
            grnt_q  <= {BUS_MASTER_CH{DISABLE_}};
            busy_q  <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
`ifdef BUS_ARB_TIMEOUT_EN
            tmo_q <= 1'b0;
`endif
            case (state_q)
                BUS_ARB_STATE_IDLE: begin
                    if (win_vld_d) begin
                        state_q <= BUS_ARB_STATE_GRANT;
                        owner_q <= win_d;
                        grnt_q  <= grant_vec(win_d);
                        busy_q  <= 1'b1;
`ifdef BUS_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                BUS_ARB_STATE_GRANT: begin
                    if (owner_req && !tmo_hit) begin
`ifdef BUS_ARB_TIMEOUT_EN
                        cnt_q <= cnt_q + 1'b1;
`endif
                    end else begin
`ifdef BUS_ARB_TIMEOUT_EN
                        tmo_q <= tmo_hit;
                        cnt_q <= '0;
`endif
                        // Direct handover keeps the bus busy with no idle gap.
                        if (win_vld_d) begin
                            owner_q <= win_d;
                            grnt_q  <= grant_vec(win_d);
                        end else begin
                            state_q <= BUS_ARB_STATE_IDLE;
                            grnt_q  <= {BUS_MASTER_CH{DISABLE_}};
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: state_q <= BUS_ARB_STATE_IDLE;
            endcase
        end
    end

    assign BusGrnt_ = grnt_q;
    assign BusOwner = owner_q;
    assign ArbBusy  = busy_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed vector table, corner sequences
// and randomized requests against a behavioural round-robin model.
module tb_bus_arbiter;

    localparam int TB_TMO = 8;

    logic       clk;
    logic       reset_;
    logic [3:0] busreq;
    logic [3:0] BusGrnt_;
    logic [1:0] BusOwner;
    logic       ArbBusy;
    logic       ArbTimeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int m_owner;
    bit m_gr;
    int m_cnt;
    bit m_tmo;

    typedef struct {
        logic [3:0] req;
        logic [3:0] grnt;
        logic [1:0] own;
        logic       busy;
    } vec_t;

    vec_t tbl[12];

    bus_arbiter #(.TIMEOUT_CYCLES(TB_TMO)) dut (
        .clk        (clk),
        .reset_     (reset_),
        .BusReq_    (busreq),
        .BusGrnt_   (BusGrnt_),
        .BusOwner   (BusOwner),
        .ArbBusy    (ArbBusy),
        .ArbTimeout (ArbTimeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_owner = 0;
        m_gr    = 1'b0;
        m_cnt   = 0;
        m_tmo   = 1'b0;
    endfunction

    // Next-state of the model from the request levels seen at the coming edge.
    function automatic void model_step(input logic [3:0] req);
        bit hit;
        int w;
        m_tmo = 1'b0;
        w     = -1;
        if (!m_gr) begin
            for (int k = 4; k >= 1; k--)
                if (req[(m_owner + k) % 4] == 1'b0) w = (m_owner + k) % 4;
            if (w >= 0) begin
                m_gr    = 1'b1;
                m_owner = w;
                m_cnt   = 0;
            end
        end else begin
            hit = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            hit = (req[m_owner] == 1'b0) && (m_cnt == TB_TMO - 1);
`endif
            if (req[m_owner] == 1'b0 && !hit) begin
                m_cnt++;
            end else begin
                m_tmo = hit;
                m_cnt = 0;
                for (int k = 3; k >= 1; k--)
                    if (req[(m_owner + k) % 4] == 1'b0) w = (m_owner + k) % 4;
                if (w >= 0) m_owner = w;
                else        m_gr    = 1'b0;
            end
        end
    endfunction

    task automatic check_model();
        logic [3:0] eg;
        eg = 4'hF;
        if (m_gr) eg[m_owner] = 1'b0;
        check("model_grant", 32'(BusGrnt_), 32'(eg));
        check("model_owner", 32'(BusOwner), 32'(m_owner));
        check("model_busy", 32'(ArbBusy), 32'(m_gr));
        check("model_timeout", 32'(ArbTimeout), 32'(m_tmo));
    endtask

    task automatic step();
        model_step(busreq);
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic do_reset();
        reset_ = 1'b0;
        busreq = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset_grant", 32'(BusGrnt_), 32'hF);
        check("reset_owner", 32'(BusOwner), 32'h0);
        check("reset_busy", 32'(ArbBusy), 32'h0);
        check("reset_timeout", 32'(ArbTimeout), 32'h0);
        @(negedge clk);
        reset_ = 1'b1;
    endtask

    initial begin
        int order[$];
        int held;
        int prev_own;
        logic [3:0] flip;

        tbl[0]  = '{4'b1110, 4'b1110, 2'd0, 1'b1};
        tbl[1]  = '{4'b0010, 4'b1110, 2'd0, 1'b1};
        tbl[2]  = '{4'b0011, 4'b1011, 2'd2, 1'b1};
        tbl[3]  = '{4'b1011, 4'b1011, 2'd2, 1'b1};
        tbl[4]  = '{4'b1111, 4'b1111, 2'd2, 1'b0};
        tbl[5]  = '{4'b0110, 4'b0111, 2'd3, 1'b1};
        tbl[6]  = '{4'b1101, 4'b1101, 2'd1, 1'b1};
        tbl[7]  = '{4'b1111, 4'b1111, 2'd1, 1'b0};
        tbl[8]  = '{4'b0110, 4'b0111, 2'd3, 1'b1};
        tbl[9]  = '{4'b1111, 4'b1111, 2'd3, 1'b0};
        tbl[10] = '{4'b0111, 4'b0111, 2'd3, 1'b1};
        tbl[11] = '{4'b1111, 4'b1111, 2'd3, 1'b0};

        busreq = 4'hF;
        model_reset();
        do_reset();

        for (int i = 0; i < 12; i++) begin
            busreq = tbl[i].req;
            step();
            check($sformatf("tbl%0d_grant", i), 32'(BusGrnt_), 32'(tbl[i].grnt));
            check($sformatf("tbl%0d_owner", i), 32'(BusOwner), 32'(tbl[i].own));
            check($sformatf("tbl%0d_busy", i), 32'(ArbBusy), 32'(tbl[i].busy));
        end

        // Round robin: everyone requesting, each owner releases after 3 granted cycles.
        do_reset();
        busreq = 4'b1110;
        step();
        order.push_back(int'(BusOwner));
        prev_own = int'(BusOwner);
        held = 1;
        for (int i = 0; i < 60 && order.size() < 5; i++) begin
            busreq = 4'b0000;
            if (held >= 3) busreq[m_owner] = 1'b1;
            prev_own = m_owner;
            step();
            held = (m_owner != prev_own) ? 1 : held + 1;
            if (int'(BusOwner) != order[order.size()-1]) order.push_back(int'(BusOwner));
        end
        check("rr_order_len", 32'(order.size()), 32'd5);
        for (int i = 0; i < order.size() && i < 5; i++)
            check($sformatf("rr_order%0d", i), 32'(order[i]), 32'(i % 4));

        // Reset asserted mid-grant deasserts the grant without waiting for a clock.
        busreq = 4'b1111;
        step();
        busreq = 4'b1011;
        step();
        check("pre_reset_grant", 32'(BusGrnt_), 32'b1011);
        reset_ = 1'b0;
        #1;
        check("async_reset_grant", 32'(BusGrnt_), 32'hF);
        check("async_reset_busy", 32'(ArbBusy), 32'h0);
        @(negedge clk);
        reset_ = 1'b1;
        model_reset();
        busreq = 4'b1110;
        step();
        check("post_reset_grant", 32'(BusGrnt_), 32'b1110);
        check("post_reset_owner", 32'(BusOwner), 32'd0);

`ifdef BUS_ARB_TIMEOUT_EN
        // Master 0 holds forever while master 1 waits: revoke after 8 granted cycles.
        do_reset();
        busreq = 4'b1110;
        step();
        busreq = 4'b1100;
        for (int i = 0; i < TB_TMO - 1; i++) begin
            step();
            check("tmo_hold_grant", 32'(BusGrnt_), 32'b1110);
            check("tmo_hold_pulse", 32'(ArbTimeout), 32'h0);
        end
        step();
        check("tmo_revoke_grant", 32'(BusGrnt_), 32'b1101);
        check("tmo_revoke_pulse", 32'(ArbTimeout), 32'h1);
        step();
        check("tmo_pulse_end", 32'(ArbTimeout), 32'h0);
`endif

        // Randomized requests: each bit flips with probability 1/4 per cycle.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            flip   = 4'($urandom) & 4'($urandom);
            busreq = busreq ^ flip;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
